// File: rtl/multi_channel_temperature_calculator.sv
// Per-channel temperature = base + coef * sensor, via a shared serial shift-add multiplier.
// Define TEMP_ALARM_EN to add the per-channel over-threshold alarm flags.
module multi_channel_temperature_calculator #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned BASE_W   = 8,
  parameter int unsigned COEF_W   = 4,
  parameter int unsigned SENSOR_W = 4,
  parameter int unsigned OUT_W    = 8,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [BASE_W-1:0]   in_base,
  input  logic [COEF_W-1:0]   in_coef,
  input  logic [SENSOR_W-1:0] in_sensor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [OUT_W-1:0]    out_temp,
  output logic                out_sat,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [OUT_W-1:0]    rd_temp
`ifdef TEMP_ALARM_EN
  ,
  input  logic [OUT_W-1:0]    alarm_thresh,
  output logic [CHANNELS-1:0] alarm
`endif
);

  localparam int unsigned PROD_W = COEF_W + SENSOR_W;
  localparam int unsigned SUM_W  = ((BASE_W > PROD_W) ? BASE_W : PROD_W) + 1;
  localparam int unsigned WIDE_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
  localparam int unsigned CNT_W  = (SENSOR_W > 1) ? $clog2(SENSOR_W) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StSum, StOut} state_e;

  state_e state_q, state_d;

  logic [CH_W-1:0]     ch_q;
  logic [BASE_W-1:0]   base_q;
  logic [PROD_W-1:0]   mcand_q;
  logic [SENSOR_W-1:0] mplier_q;
  logic [PROD_W-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CH_W-1:0]     out_ch_q;
  logic [OUT_W-1:0]    out_temp_q;
  logic                out_sat_q;
  logic [OUT_W-1:0]    mem_q [CHANNELS];

  logic [SUM_W-1:0]    sum;
  logic [WIDE_W-1:0]   sum_wide;
  logic                sat;
  logic [OUT_W-1:0]    temp_sat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StMul;
      StMul:   if (cnt_q == CNT_W'(SENSOR_W - 1)) state_d = StSum;
      StSum:   state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StOut);
  end

  // Widen before clamping so the compare is correct for any OUT_W vs SUM_W.
  assign sum      = SUM_W'(base_q) + SUM_W'(acc_q);
  assign sum_wide = WIDE_W'(sum);
  assign sat      = sum_wide > WIDE_W'({OUT_W{1'b1}});
  assign temp_sat = sat ? {OUT_W{1'b1}} : sum_wide[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      base_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_ch_q   <= '0;
      out_temp_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            ch_q     <= in_ch;
            base_q   <= in_base;
            mcand_q  <= PROD_W'(in_coef);
            mplier_q <= in_sensor;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        StMul: begin
          // LSB-first: mcand_q holds coef << i for multiplier bit i.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        StSum: begin
          out_ch_q   <= ch_q;
          out_temp_q <= temp_sat;
          out_sat_q  <= sat;
        end
        default: ;
      endcase
    end
  end

  // Channel bank; an out-of-range ch_q matches no entry and writes nothing.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (rst) begin
        mem_q[c] <= '0;
      end else if (state_q == StSum && ch_q == CH_W'(c)) begin
        mem_q[c] <= temp_sat;
      end
    end
  end

  always_comb begin
    rd_temp = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (rd_ch == CH_W'(c)) rd_temp = mem_q[c];
    end
  end

`ifdef TEMP_ALARM_EN
  logic [CHANNELS-1:0] alarm_q;

  // Re-evaluated only when its channel is written; threshold changes alone do nothing.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (rst) begin
        alarm_q[c] <= 1'b0;
      end else if (state_q == StSum && ch_q == CH_W'(c)) begin
        alarm_q[c] <= temp_sat > alarm_thresh;
      end
    end
  end

  assign alarm = alarm_q;
`endif

  assign out_ch   = out_ch_q;
  assign out_temp = out_temp_q;
  assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_multi_channel_temperature_calculator.sv
// Directed bench for multi_channel_temperature_calculator (default parameters);
// the alarm scenario runs when TEMP_ALARM_EN is defined.
module tb_multi_channel_temperature_calculator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  logic [7:0] in_base;
  logic [3:0] in_coef;
  logic [3:0] in_sensor;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [7:0] out_temp;
  logic       out_sat;
  logic [1:0] rd_ch;
  logic [7:0] rd_temp;
`ifdef TEMP_ALARM_EN
  logic [7:0] alarm_thresh;
  logic [3:0] alarm;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [10:0] q [$];

  multi_channel_temperature_calculator dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .in_base     (in_base),
    .in_coef     (in_coef),
    .in_sensor   (in_sensor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_temp    (out_temp),
    .out_sat     (out_sat),
    .rd_ch       (rd_ch),
    .rd_temp     (rd_temp)
`ifdef TEMP_ALARM_EN
    ,
    .alarm_thresh(alarm_thresh),
    .alarm       (alarm)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every completed output handshake as {ch, temp, sat}.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) q.push_back({out_ch, out_temp, out_sat});
  end

  task automatic send(input logic [1:0] ch, input logic [7:0] b, input logic [3:0] c,
                      input logic [3:0] s, output int acc_cyc);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_ch     = ch;
    in_base   = b;
    in_coef   = c;
    in_sensor = s;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // Called one cycle after acceptance; lat counts cycles after acceptance.
  task automatic wait_out(output int lat, output logic [7:0] rd_at_sum);
    lat       = 1;
    rd_at_sum = 8'hxx;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) rd_at_sum = rd_temp;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rd_ch = 2'd0;
    in_ch = '0; in_base = '0; in_coef = '0; in_sensor = '0;
`ifdef TEMP_ALARM_EN
    alarm_thresh = 8'd40;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({out_ch, out_temp, out_sat} !== 11'd0) begin
      bad++; $display("FAIL reset_outputs got=%h/%0d/%b exp=0/0/0", out_ch, out_temp, out_sat);
    end
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c); #1;
      total++; if (rd_temp !== 8'd0) begin bad++; $display("FAIL reset_rd ch%0d got=%0d exp=0", c, rd_temp); end
    end
`ifdef TEMP_ALARM_EN
    total++; if (alarm !== 4'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=0000", alarm); end
`endif
  endtask

  task automatic test_basic();
    int a, lat;
    logic [7:0] rs;
    q.delete();
    out_ready = 1'b1; rd_ch = 2'd0;
    send(2'd0, 8'd30, 4'd4, 4'd2, a);
    wait_out(lat, rs);
    total++; if (lat != 6) begin bad++; $display("FAIL basic_latency got=%0d exp=6", lat); end
    total++; if (out_temp !== 8'd38 || out_sat !== 1'b0 || out_ch !== 2'd0) begin
      bad++; $display("FAIL basic_result got=%0d/%b/%0d exp=38/0/0", out_temp, out_sat, out_ch);
    end
    total++; if (rs !== 8'd0) begin bad++; $display("FAIL basic_rd_during_sum got=%0d exp=0", rs); end
    total++; if (rd_temp !== 8'd38) begin bad++; $display("FAIL basic_rd_after got=%0d exp=38", rd_temp); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_after_hs got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    total++; if (q.size() != 1) begin bad++; $display("FAIL basic_hs_count got=%0d exp=1", q.size()); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, lat;
    logic [7:0] rs;
    q.delete();
    out_ready = 1'b1;
    send(2'd3, 8'd35, 4'd4, 4'd2, a0);
    send(2'd1, 8'd0, 4'd15, 4'd15, a1);
    wait_out(lat, rs);
    @(posedge clk); #1;
    total++; if (a1 - a0 != 7) begin bad++; $display("FAIL b2b_interval got=%0d exp=7", a1 - a0); end
    total++; if (q.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", q.size()); end
    else begin
      total++; if (q[0] !== {2'd3, 8'd43, 1'b0}) begin bad++; $display("FAIL b2b_first got=%h exp=%h", q[0], {2'd3, 8'd43, 1'b0}); end
      total++; if (q[1] !== {2'd1, 8'd225, 1'b0}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", q[1], {2'd1, 8'd225, 1'b0}); end
    end
    rd_ch = 2'd3; #1;
    total++; if (rd_temp !== 8'd43) begin bad++; $display("FAIL b2b_rd3 got=%0d exp=43", rd_temp); end
    rd_ch = 2'd1; #1;
    total++; if (rd_temp !== 8'd225) begin bad++; $display("FAIL b2b_rd1 got=%0d exp=225", rd_temp); end
  endtask

  task automatic test_saturation();
    int a, lat;
    logic [7:0] rs;
    q.delete();
    out_ready = 1'b1; rd_ch = 2'd0;
    send(2'd0, 8'd255, 4'd15, 4'd15, a);
    wait_out(lat, rs);
    total++; if (out_temp !== 8'd255 || out_sat !== 1'b1) begin
      bad++; $display("FAIL sat_clamp got=%0d/%b exp=255/1", out_temp, out_sat);
    end
    @(posedge clk); #1;
    send(2'd0, 8'd10, 4'd0, 4'd9, a);
    wait_out(lat, rs);
    total++; if (lat != 6) begin bad++; $display("FAIL zero_coef_latency got=%0d exp=6", lat); end
    total++; if (out_temp !== 8'd10 || out_sat !== 1'b0) begin
      bad++; $display("FAIL zero_coef_result got=%0d/%b exp=10/0", out_temp, out_sat);
    end
    total++; if (rs !== 8'd255) begin bad++; $display("FAIL sat_rd_stored got=%0d exp=255", rs); end
    @(posedge clk); #1;
    total++; if (rd_temp !== 8'd10) begin bad++; $display("FAIL zero_coef_rd got=%0d exp=10", rd_temp); end
  endtask

  task automatic test_backpressure();
    int a, lat;
    logic [7:0] rs;
    q.delete();
    out_ready = 1'b0;
    send(2'd2, 8'd20, 4'd3, 4'd5, a);
    wait_out(lat, rs);
    total++; if (lat != 6) begin bad++; $display("FAIL bp_latency got=%0d exp=6", lat); end
    in_valid = 1'b1; in_ch = 2'd1; in_base = 8'd1; in_coef = 4'd1; in_sensor = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_temp !== 8'd35 || out_ch !== 2'd2 || out_sat !== 1'b0
                   || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc%0d got v=%b t=%0d ch=%0d s=%b rdy=%b exp 1/35/2/0/0",
                        i, out_valid, out_temp, out_ch, out_sat, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_after_hs got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    send(2'd1, 8'd1, 4'd1, 4'd1, a);
    wait_out(lat, rs);
    @(posedge clk); #1;
    total++; if (q.size() != 2 || q[0] !== {2'd2, 8'd35, 1'b0} || q[1] !== {2'd1, 8'd2, 1'b0}) begin
      bad++; $display("FAIL bp_results got n=%0d first=%h exp n=2 %h %h", q.size(),
                      (q.size() > 0) ? q[0] : 11'h0, {2'd2, 8'd35, 1'b0}, {2'd1, 8'd2, 1'b0});
    end
  endtask

  task automatic test_reset_abort();
    int a, seen;
    q.delete();
    out_ready = 1'b1; rd_ch = 2'd2;
    send(2'd2, 8'd50, 4'd2, 4'd3, a);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_out_valid got=%0d cycles exp=0", seen); end
    total++; if (rd_temp !== 8'd0) begin bad++; $display("FAIL abort_rd2 got=%0d exp=0", rd_temp); end
    total++; if (q.size() != 0) begin bad++; $display("FAIL abort_hs_count got=%0d exp=0", q.size()); end
  endtask

`ifdef TEMP_ALARM_EN
  task automatic test_alarm();
    int a, lat;
    logic [7:0] rs;
    out_ready = 1'b1; alarm_thresh = 8'd40;
    send(2'd2, 8'd35, 4'd4, 4'd2, a);
    wait_out(lat, rs);
    total++; if (alarm !== 4'b0100) begin bad++; $display("FAIL alarm_set got=%b exp=0100", alarm); end
    @(posedge clk); #1;
    alarm_thresh = 8'd100;
    @(posedge clk); #1;
    total++; if (alarm !== 4'b0100) begin bad++; $display("FAIL alarm_thresh_only got=%b exp=0100", alarm); end
    alarm_thresh = 8'd40;
    send(2'd2, 8'd30, 4'd4, 4'd2, a);
    wait_out(lat, rs);
    total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL alarm_clear got=%b exp=0000", alarm); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_reset_abort();
`ifdef TEMP_ALARM_EN
    test_alarm();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
